// File: rtl/text_stream_scheduler.sv
// rtl/text_stream_scheduler.sv - round-robin shared character ROM reader with valid/ready character output
// Optional build macro: SCHED_LOOP_EN (repeat the granted message while its request stays high)
module text_stream_scheduler #(
   parameter int ADDR_W   = 8,
   parameter int LEN_W    = 8,
   parameter int NREQ     = 2,
   parameter int TICK_DIV = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NREQ-1:0]        req_i,
   input  logic [NREQ*ADDR_W-1:0] base_addr_i,
   input  logic [NREQ*LEN_W-1:0]  msg_len_i,
   output logic [NREQ-1:0]        grant_o,
   output logic                   done_o,
   output logic                   busy_o,
   output logic [ADDR_W-1:0]      rom_addr_o,
   input  logic [7:0]             rom_data_i,
   output logic [7:0]             char_out_o,
   output logic                   char_valid_o,
   input  logic                   char_ready_i
);

   localparam int IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int GAP_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int GAP_LAST = (TICK_DIV > 1) ? TICK_DIV - 2 : 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_LOAD,
      S_SHOW,
      S_GAP,
      S_DONE
   } state_e;

   state_e              state_q;
   logic [NREQ-1:0]     grant_q;
   logic [IDX_W-1:0]    gidx_q;
   logic [IDX_W-1:0]    rr_q;
   logic [ADDR_W-1:0]   base_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    idx_q;
   logic [GAP_W-1:0]    gap_q;
   logic [ADDR_W-1:0]   rom_addr_q;
   logic [7:0]          char_q;
   logic                valid_q;
   logic                done_q;
   logic                busy_q;

   logic                arb_found;
   logic [IDX_W-1:0]    arb_idx;
   logic [NREQ-1:0]     arb_onehot;
   logic [ADDR_W-1:0]   arb_base;
   logic [LEN_W-1:0]    arb_len;
   logic [IDX_W-1:0]    rr_next;

   // Pick the first asserted request at or after the round-robin pointer, wrapping around.
   // The loop runs from the farthest candidate down so the nearest one wins.
   always_comb begin : arb_comb
      int cand;
      cand       = 0;
      arb_found  = 1'b0;
      arb_idx    = '0;
      arb_onehot = '0;
      arb_base   = '0;
      arb_len    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = (int'(rr_q) + k) % NREQ;
         if (req_i[cand]) begin
            arb_found        = 1'b1;
            arb_idx          = IDX_W'(cand);
            arb_onehot       = '0;
            arb_onehot[cand] = 1'b1;
            arb_base         = base_addr_i[cand*ADDR_W +: ADDR_W];
            arb_len          = msg_len_i[cand*LEN_W +: LEN_W];
         end
      end
   end

   // Pointer handed to the requester after the one just served.
   always_comb begin
      rr_next = '0;
      if (gidx_q != IDX_W'(NREQ - 1)) begin
         rr_next = gidx_q + 1'b1;
      end
   end

   // Message walker: arbitration, ROM addressing, character handshake, gap timing.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         gidx_q     <= '0;
         rr_q       <= '0;
         base_q     <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         gap_q      <= '0;
         rom_addr_q <= '0;
         char_q     <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arb_found) begin
                  grant_q    <= arb_onehot;
                  gidx_q     <= arb_idx;
                  base_q     <= arb_base;
                  len_q      <= arb_len;
                  idx_q      <= '0;
                  rom_addr_q <= arb_base;
                  busy_q     <= 1'b1;
                  if (arb_len == '0) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_ADDR;
                  end
               end
            end
            // ROM samples rom_addr during this cycle.
            S_ADDR: begin
               state_q <= S_LOAD;
            end
            S_LOAD: begin
               char_q  <= rom_data_i;
               valid_q <= 1'b1;
               state_q <= S_SHOW;
            end
            S_SHOW: begin
               if (valid_q && char_ready_i) begin
                  valid_q <= 1'b0;
                  idx_q   <= idx_q + 1'b1;
                  if (idx_q == len_q - 1'b1) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     rom_addr_q <= base_q + ADDR_W'(idx_q) + ADDR_W'(1);
                     gap_q      <= '0;
                     if (TICK_DIV > 1) begin
                        state_q <= S_GAP;
                     end else begin
                        state_q <= S_ADDR;
                     end
                  end
               end
            end
            S_GAP: begin
               if (gap_q == GAP_W'(GAP_LAST)) begin
                  state_q <= S_ADDR;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            S_DONE: begin
               done_q <= 1'b0;
`ifdef SCHED_LOOP_EN
               if (req_i[gidx_q] && (len_q != '0)) begin
                  rom_addr_q <= base_q;
                  idx_q      <= '0;
                  gap_q      <= '0;
                  if (TICK_DIV > 1) begin
                     state_q <= S_GAP;
                  end else begin
                     state_q <= S_ADDR;
                  end
               end else begin
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  rr_q    <= rr_next;
                  state_q <= S_IDLE;
               end
`else
               grant_q <= '0;
               busy_q  <= 1'b0;
               rr_q    <= rr_next;
               state_q <= S_IDLE;
`endif
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign grant_o      = grant_q;
   assign done_o       = done_q;
   assign busy_o       = busy_q;
   assign rom_addr_o   = rom_addr_q;
   assign char_out_o   = char_q;
   assign char_valid_o = valid_q;

endmodule
